// File: rtl/mem_seq.sv
// mem_seq: debounced button sequencer driving the 64x8 memory stage.
// Auto-scan of all RAM locations is compiled in when MEM_SEQ_SCAN_EN is defined.
module mem_seq #(
    parameter int DB_CYCLES  = 50000,
    parameter int SCAN_TICKS = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_save,
    input  logic       btn_write,
    input  logic       btn_scan,
    input  logic [7:0] sw,
    input  logic       sw_show,
    output logic       save_data,
    output logic       write_en,
    output logic       show_reg,
    output logic [7:0] d_in,
    output logic       busy
);
`ifdef MEM_SEQ_SCAN_EN
    localparam int NB = 3;
    localparam int TW = SCAN_TICKS > 1 ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TW-1:0] TK_MAX = TW'(SCAN_TICKS - 1);
    typedef enum logic [1:0] {IDLE, SAVE, WRITE, SCAN} state_t;
    logic [TW-1:0] tk_q, tk_d;
    logic [5:0] addr_q, addr_d;
    logic [NB-1:0] raw;
    assign raw = {btn_scan, btn_write, btn_save};
`else
    localparam int NB = 2;
    typedef enum logic [1:0] {IDLE, SAVE, WRITE} state_t;
    logic [NB-1:0] raw;
    logic unused_scan;
    assign raw = {btn_write, btn_save};
    assign unused_scan = btn_scan | (SCAN_TICKS < 1);
`endif
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);

    state_t state_q, state_d;
    logic [NB-1:0] s1_q, s2_q, lvl_q, lvl_d, press_q, press_d;
    logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
    logic wr_pend_q, wr_pend_d, scan_nx;
    logic [5:0] addr_nx;
    logic save_data_q, save_data_d, write_en_q, write_en_d;
    logic show_reg_q, show_reg_d, busy_q, busy_d;
    logic [7:0] d_in_q, d_in_d;

    // A level flips only after DB_CYCLES consecutive mismatches; a rising flip is a press.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            lvl_d[i]   = lvl_q[i];
            press_d[i] = 1'b0;
            cnt_d[i]   = '0;
            if (s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == DB_MAX) begin
                    lvl_d[i]   = s2_q[i];
                    press_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            lvl_q       <= '0;
            press_q     <= '0;
            cnt_q       <= '0;
            state_q     <= IDLE;
            wr_pend_q   <= 1'b0;
            save_data_q <= 1'b0;
            write_en_q  <= 1'b0;
            show_reg_q  <= 1'b0;
            busy_q      <= 1'b0;
            d_in_q      <= 8'h00;
`ifdef MEM_SEQ_SCAN_EN
            tk_q        <= '0;
            addr_q      <= '0;
`endif
        end else begin
            s1_q        <= raw;
            s2_q        <= s1_q;
            lvl_q       <= lvl_d;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            wr_pend_q   <= wr_pend_d;
            save_data_q <= save_data_d;
            write_en_q  <= write_en_d;
            show_reg_q  <= show_reg_d;
            busy_q      <= busy_d;
            d_in_q      <= d_in_d;
`ifdef MEM_SEQ_SCAN_EN
            tk_q        <= tk_d;
            addr_q      <= addr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_pend_d = wr_pend_q;
`ifdef MEM_SEQ_SCAN_EN
        tk_d      = tk_q;
        addr_d    = addr_q;
`endif
        case (state_q)
            IDLE: begin
                state_d   = press_q[0] ? SAVE : press_q[1] ? WRITE : IDLE;
                wr_pend_d = press_q[0] & press_q[1];
`ifdef MEM_SEQ_SCAN_EN
                if (press_q[2]) begin
                    state_d   = SCAN;
                    wr_pend_d = 1'b0;
                end
`endif
            end
            SAVE: begin
                state_d   = (wr_pend_q | press_q[1]) ? WRITE : IDLE;
                wr_pend_d = 1'b0;
            end
            WRITE: state_d = IDLE;
`ifdef MEM_SEQ_SCAN_EN
            SCAN: begin
                tk_d   = (tk_q == TK_MAX) ? '0 : tk_q + 1'b1;
                addr_d = (tk_q == TK_MAX) ? addr_q + 1'b1 : addr_q;
                if (press_q[2] || (tk_q == TK_MAX && addr_q == 6'd63)) begin
                    state_d = IDLE;
                    tk_d    = '0;
                    addr_d  = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each strobe aligns with its state.
    always_comb begin
`ifdef MEM_SEQ_SCAN_EN
        scan_nx = state_d == SCAN;
        addr_nx = addr_d;
`else
        scan_nx = 1'b0;
        addr_nx = '0;
`endif
        save_data_d = state_d == SAVE;
        write_en_d  = state_d == WRITE;
        busy_d      = scan_nx;
        show_reg_d  = scan_nx ? 1'b1 : (state_d == IDLE) ? sw_show : show_reg_q;
        d_in_d      = scan_nx ? {2'b00, addr_nx} :
                      (state_d == IDLE || state_q == IDLE) ? sw : d_in_q;
    end

    assign save_data = save_data_q;
    assign write_en  = write_en_q;
    assign show_reg  = show_reg_q;
    assign busy      = busy_q;
    assign d_in      = d_in_q;
endmodule

// File: doc/mem_seq.md
# mem_seq

Front-end sequencer that sits directly upstream of the 64x8 register/RAM memory stage and drives its control and data inputs from board switches and pushbuttons. It synchronises and debounces three raw buttons and converts presses into single-cycle `save_data` / `write_en` strobes. It also provides an optional auto-scan mode that walks the display path through all 64 RAM locations. All outputs are registered and connect one-to-one to the memory stage inputs of the same name.

## Interface
Parameters:
- `DB_CYCLES`, 50000: consecutive stable cycles required to accept a button level change (min 2).
- `SCAN_TICKS`, 25000000: cycles each address is held during scan (min 1).

Ports:
- `clk`: input, 1 bit. Single clock; all state is on the rising edge.
- `rst`: input, 1 bit. Reset is asynchronous and active-low.
- `btn_save`: input, 1 bit. Raw pushbutton, asynchronous; press loads the data register.
- `btn_write`: input, 1 bit. Raw pushbutton, asynchronous; press writes the data register into RAM.
- `btn_scan`: input, 1 bit. Raw pushbutton, asynchronous; starts or aborts scan.
- `sw`: input, 8 bits. Slide switches: data, or address in `sw[5:0]`. Quasi-static, not synchronised.
- `sw_show`: input, 1 bit. Switch selecting the display source (RAM or register) in IDLE.
- `save_data`: output, 1 bit. One-cycle strobe to the memory stage.
- `write_en`: output, 1 bit. One-cycle strobe to the memory stage.
- `show_reg`: output, 1 bit. Display source select to the memory stage.
- `d_in`: output, 8 bits. Data/address bus to the memory stage.
- `busy`: output, 1 bit. High while a scan is in progress.

## Operation
- Button path, identical for each button:
  - 2-flop synchroniser.
  - Debounce counter (`$clog2(DB_CYCLES)` bits). It increments while the synchronised value differs from the debounced level and clears to 0 on any match.
  - When a mismatch is present and the counter equals `DB_CYCLES-1`, the debounced level toggles and the counter clears.
  - Press event: debounced level goes 0→1. Release produces no event.
- FSM states: IDLE, SAVE, WRITE, SCAN.
- IDLE:
  - `d_in <= sw`, `show_reg <= sw_show` every cycle.
  - Save press → SAVE. Write press → WRITE.
  - Save and write press in the same cycle → SAVE, then WRITE. The write therefore stores the newly saved value.
  - Scan press → SCAN, with priority over save and write; those presses are discarded.
- SAVE: `save_data` = 1 for exactly this cycle. Next state is WRITE if a write is pending, else IDLE.
- WRITE: `write_en` = 1 for exactly this cycle. `d_in` holds the `sw` value latched on entry, so the address is `sw[5:0]`. Next state IDLE.
- SCAN:
  - `busy` = 1, `show_reg` = 1, `d_in = {2'b00, scan_addr}`.
  - `scan_addr` starts at 0 and holds for `SCAN_TICKS` cycles per address.
  - After address 63 has been held for its full period → IDLE, and `scan_addr` resets to 0. There is no wrap to 0.
  - A second scan press aborts to IDLE immediately.
  - Save and write presses are discarded. `save_data` and `write_en` stay 0 throughout.
- Reset values, applied asynchronously:
  - `save_data` = 0, `write_en` = 0, `show_reg` = 0, `d_in` = 8'h00, `busy` = 0.
  - State IDLE, all counters 0, debounced levels 0, synchronisers 0.
- Reset mid-scan or mid-strobe: all outputs return to reset values at once. No strobe completes after reset is released.

## Timing
- Raw button rising at time t, stable thereafter:
  - Synchroniser output high after the 2nd clock edge.
  - Debounced level high at edge 2+`DB_CYCLES`.
  - Strobe (`save_data`, `write_en`, or scan entry) asserted after edge 3+`DB_CYCLES`, lasting one cycle.
- Any bounce shorter than `DB_CYCLES` cycles produces no event.
- Combined save+write: `save_data` at cycle N, `write_en` at cycle N+1. Never both high in the same cycle.
- IDLE `d_in` / `show_reg` track `sw` / `sw_show` with 1-cycle latency.
- Scan: address k is presented for exactly `SCAN_TICKS` cycles. `busy` is high for 64×`SCAN_TICKS` cycles, then falls in the same cycle as `show_reg` returns to `sw_show`.
- Button held indefinitely: exactly one event. The next event requires release, debounced low, then press again.

## Configuration
- `MEM_SEQ_SCAN_EN` defined: SCAN state, scan counters and `btn_scan` path are compiled in, as described above.
- `MEM_SEQ_SCAN_EN` undefined:
  - The `btn_scan` port still exists but is ignored.
  - SCAN state and counters are absent.
  - `busy` is tied 0.
  - FSM has states IDLE, SAVE, WRITE only.

## Test plan
All scenarios use `DB_CYCLES`=4, `SCAN_TICKS`=3.
- Reset, then `sw`=8'hA5, `sw_show`=1 → after 1 cycle `d_in`=8'hA5, `show_reg`=1. All strobes 0 with reset asserted.
- `btn_save` high and held → `save_data` high for exactly 1 cycle starting 7 edges after the first sample. No second pulse while held.
- `btn_write` toggling every 2 cycles for 20 cycles, then low → no `write_en`.
- `btn_save` and `btn_write` rise together with `sw`=8'h2C → `save_data` at cycle N, `write_en` at N+1, `d_in`=8'h2C during both.
- Scan press (macro defined) → `busy`=1 for 192 cycles; `d_in` steps 8'h00..8'h3F, 3 cycles each; `show_reg`=1; then IDLE.
- `rst` pulled low while `scan_addr`=8'h15 → `busy`=0 and `d_in`=8'h00 immediately. After release, state is IDLE and `d_in` tracks `sw`.
